// File: rtl/rice_pkg.sv
// ---------------------------------------------------------------------------
// rice_pkg -- definitions shared by the Rice residual encoder blocks.
//   state_t      : FSM states of rice_stream_writer (ESCW/RAW are only entered
//                  when the escape feature is built in)
//   RICE_PARAM_W : width of a Rice parameter field
//   SAMPLE_W     : width of a residual sample
//   HDR_W        : width of the residual header (coding method + order)
//   RICE_ESCAPE  : parameter value that marks an escaped partition
// ---------------------------------------------------------------------------
package rice_pkg;

   localparam int         RICE_PARAM_W = 4;
   localparam int         SAMPLE_W     = 16;
   localparam int         HDR_W        = 6;
   localparam logic [3:0] RICE_ESCAPE  = 4'hF;

   typedef enum logic [3:0] {
      IDLE  = 4'd0,
      HDR   = 4'd1,
      PWAIT = 4'd2,
      PARAM = 4'd3,
      SWAIT = 4'd4,
      UNARY = 4'd5,
      STOP  = 4'd6,
      LSB   = 4'd7,
      DONE  = 4'd8,
      ESCW  = 4'd9,
      RAW   = 4'd10
   } state_t;

endpackage

// File: rtl/rice_stream_writer_if.sv
// ---------------------------------------------------------------------------
// rice_stream_writer_if -- streaming channels of rice_stream_writer.
//   Parameter channel : iRiceParam, iParamValid  -> oParamReq
//   Sample channel    : iSample, iSampleValid    -> oSampleReady
//   Bit channel       : oBit, oBitValid          <- iBitReady
// Handshake: on every channel a word moves on the rising clock edge where
// the valid-side and the ready-side (oParamReq for parameters) are both 1;
// a source holds its data stable while valid is 1 and the transfer has
// not yet happened.
// Modports: slave = the writer, master = whoever feeds and drains it.
// ---------------------------------------------------------------------------
interface rice_stream_writer_if;
   import rice_pkg::*;

   logic [RICE_PARAM_W-1:0]    iRiceParam;
   logic                       iParamValid;
   logic                       oParamReq;
   logic signed [SAMPLE_W-1:0] iSample;
   logic                       iSampleValid;
   logic                       oSampleReady;
   logic                       oBit;
   logic                       oBitValid;
   logic                       iBitReady;

   modport slave (
      input  iRiceParam, iParamValid, iSample, iSampleValid, iBitReady,
      output oParamReq, oSampleReady, oBit, oBitValid
   );

   modport master (
      output iRiceParam, iParamValid, iSample, iSampleValid, iBitReady,
      input  oParamReq, oSampleReady, oBit, oBitValid
   );

endinterface

// File: rtl/rice_fold.sv
// ---------------------------------------------------------------------------
// rice_fold -- combinational zigzag fold of a signed residual onto an
// unsigned code: 0,-1,1,-2,2,... -> 0,1,2,3,4,...
//   iSample : signed residual
//   oFolded : (x << 1) ^ (x >>> (SAMPLE_W-1)), unsigned
// ---------------------------------------------------------------------------
module rice_fold
   import rice_pkg::*;
(
   input  logic signed [SAMPLE_W-1:0] iSample,
   output logic        [SAMPLE_W-1:0] oFolded
);

   assign oFolded = {iSample[SAMPLE_W-2:0], 1'b0} ^ {SAMPLE_W{iSample[SAMPLE_W-1]}};

endmodule

// File: rtl/rice_stream_writer.sv
// ---------------------------------------------------------------------------
// rice_stream_writer -- serialises one Rice-coded residual block MSB-first.
// Stream: 2'b00, 4-bit partition order, then per partition a 4-bit Rice
// parameter followed by each sample as q zeros, a '1', and k low bits.
//   iClock, iReset  : clock, synchronous active-high reset
//   iStart          : starts a block (taken only in IDLE)
//   iBlockSize      : samples per block, captured on start
//   iPartitionOrder : 1<<order partitions, captured on start
//   iPredictorOrder : warm-up samples missing from partition 0
//   bus             : parameter / sample / bit channels (slave side)
//   oBusy, oDone    : not IDLE / one-cycle end-of-block pulse
//   oState          : current FSM state, for observation
// Build option RICE_ESCAPE_EN: parameter 15 escapes the partition to raw
// 16-bit samples (field 1111, width 10000). Without it 15 saturates to 14.
// ---------------------------------------------------------------------------
module rice_stream_writer
   import rice_pkg::*;
(
   input  logic                  iClock,
   input  logic                  iReset,
   input  logic                  iStart,
   input  logic [15:0]           iBlockSize,
   input  logic [3:0]            iPartitionOrder,
   input  logic [3:0]            iPredictorOrder,
   rice_stream_writer_if.slave   bus,
   output logic                  oBusy,
   output logic                  oDone,
   output state_t                oState
);

   localparam logic [4:0] ESC_WIDTH_WORD = 5'd16;

   state_t                  state_q, state_d;
   logic [3:0]              porder_q, porder_d;
   logic [3:0]              pred_q, pred_d;
   logic [15:0]             bsize_q, bsize_d;
   logic [15:0]             part_idx_q, part_idx_d;
   logic [15:0]             samp_left_q, samp_left_d;
   logic [15:0]             u_q, u_d;          // folded code, or raw sample when escaped
   logic [15:0]             q_q, q_d;          // unary zeros still to send
   logic [RICE_PARAM_W-1:0] k_q, k_d;
   logic                    esc_q, esc_d;
   logic [4:0]              idx_q, idx_d;      // index of the bit being offered

   logic [SAMPLE_W-1:0]     fold_u;
   logic [HDR_W-1:0]        hdr_word;
   logic [15:0]             last_part;
   logic [15:0]             part_len;
   logic [RICE_PARAM_W-1:0] k_in;
   logic                    esc_in;
   logic                    bit_valid, bit_val, xfer;
   logic                    param_req, samp_ready;
   logic                    go_after;
   state_t                  after_state;

   rice_fold u_fold (
      .iSample (bus.iSample),
      .oFolded (fold_u)
   );

   assign hdr_word  = {2'b00, porder_q};
   assign last_part = 16'((17'd1 << porder_q) - 17'd1);
   assign part_len  = bsize_q >> porder_q;

`ifdef RICE_ESCAPE_EN
   assign esc_in = (bus.iRiceParam == RICE_ESCAPE);
   assign k_in   = bus.iRiceParam;
`else
   assign esc_in = 1'b0;
   assign k_in   = (bus.iRiceParam == RICE_ESCAPE) ? 4'd14 : bus.iRiceParam;
`endif

   // Bit currently offered. k_q already holds the field to emit: the
   // escape code when escaped, otherwise the (possibly saturated) k.
   always_comb begin
      bit_valid = 1'b0;
      bit_val   = 1'b0;
      case (state_q)
         HDR:   begin bit_valid = 1'b1; bit_val = hdr_word[idx_q[2:0]];       end
         PARAM: begin bit_valid = 1'b1; bit_val = k_q[idx_q[1:0]];            end
         UNARY: begin bit_valid = 1'b1; bit_val = 1'b0;                       end
         STOP:  begin bit_valid = 1'b1; bit_val = 1'b1;                       end
         LSB:   begin bit_valid = 1'b1; bit_val = u_q[idx_q[3:0]];            end
`ifdef RICE_ESCAPE_EN
         ESCW:  begin bit_valid = 1'b1; bit_val = ESC_WIDTH_WORD[idx_q[2:0]]; end
         RAW:   begin bit_valid = 1'b1; bit_val = u_q[idx_q[3:0]];            end
`endif
         default: ;
      endcase
   end

   assign xfer = bit_valid & bus.iBitReady;

   // Where to go once a sample (or an empty partition's header) is done.
   always_comb begin
      if (samp_left_q != 16'd0)          after_state = SWAIT;
      else if (part_idx_q != last_part)  after_state = PWAIT;
      else                               after_state = DONE;
   end

   always_comb begin
      state_d     = state_q;
      porder_d    = porder_q;
      pred_d      = pred_q;
      bsize_d     = bsize_q;
      part_idx_d  = part_idx_q;
      samp_left_d = samp_left_q;
      u_d         = u_q;
      q_d         = q_q;
      k_d         = k_q;
      esc_d       = esc_q;
      idx_d       = idx_q;
      param_req   = 1'b0;
      samp_ready  = 1'b0;
      go_after    = 1'b0;

      case (state_q)
         IDLE: begin
            if (iStart) begin
               bsize_d    = iBlockSize;
               porder_d   = iPartitionOrder;
               pred_d     = iPredictorOrder;
               part_idx_d = 16'd0;
               idx_d      = 5'(HDR_W - 1);
               state_d    = HDR;
            end
         end
         HDR: begin
            if (xfer) begin
               if (idx_q == 5'd0) state_d = PWAIT;
               else               idx_d   = idx_q - 5'd1;
            end
         end
         PWAIT: begin
            param_req = 1'b1;
            if (bus.iParamValid) begin
               k_d         = k_in;
               esc_d       = esc_in;
               samp_left_d = (part_idx_q == 16'd0) ? part_len - {12'd0, pred_q} : part_len;
               idx_d       = 5'(RICE_PARAM_W - 1);
               state_d     = PARAM;
            end
         end
         PARAM: begin
            if (xfer) begin
               if (idx_q != 5'd0) idx_d = idx_q - 5'd1;
               else if (esc_q) begin
                  idx_d   = 5'd4;
                  state_d = ESCW;
               end
               else go_after = 1'b1;
            end
         end
         SWAIT: begin
            samp_ready = 1'b1;
            if (bus.iSampleValid) begin
               samp_left_d = samp_left_q - 16'd1;
               if (esc_q) begin
                  u_d     = bus.iSample;
                  idx_d   = 5'd15;
                  state_d = RAW;
               end
               else begin
                  u_d     = fold_u;
                  q_d     = fold_u >> k_q;
                  state_d = ((fold_u >> k_q) != 16'd0) ? UNARY : STOP;
               end
            end
         end
         UNARY: begin
            if (xfer) begin
               q_d = q_q - 16'd1;
               if (q_q == 16'd1) state_d = STOP;
            end
         end
         STOP: begin
            if (xfer) begin
               if (k_q != 4'd0) begin
                  idx_d   = {1'b0, k_q - 4'd1};
                  state_d = LSB;
               end
               else go_after = 1'b1;
            end
         end
`ifdef RICE_ESCAPE_EN
         LSB, ESCW, RAW: begin
`else
         LSB: begin
`endif
            if (xfer) begin
               if (idx_q == 5'd0) go_after = 1'b1;
               else               idx_d    = idx_q - 5'd1;
            end
         end
         DONE: state_d = IDLE;
         default: state_d = IDLE;
      endcase

      if (go_after) begin
         state_d = after_state;
         if (after_state == PWAIT) part_idx_d = part_idx_q + 16'd1;
      end
   end

   always_ff @(posedge iClock) begin
      if (iReset) begin
         state_q     <= IDLE;
         porder_q    <= '0;
         pred_q      <= '0;
         bsize_q     <= '0;
         part_idx_q  <= '0;
         samp_left_q <= '0;
         u_q         <= '0;
         q_q         <= '0;
         k_q         <= '0;
         esc_q       <= 1'b0;
         idx_q       <= '0;
      end
      else begin
         state_q     <= state_d;
         porder_q    <= porder_d;
         pred_q      <= pred_d;
         bsize_q     <= bsize_d;
         part_idx_q  <= part_idx_d;
         samp_left_q <= samp_left_d;
         u_q         <= u_d;
         q_q         <= q_d;
         k_q         <= k_d;
         esc_q       <= esc_d;
         idx_q       <= idx_d;
      end
   end

   assign bus.oBit         = bit_val;
   assign bus.oBitValid    = bit_valid;
   assign bus.oParamReq    = param_req;
   assign bus.oSampleReady = samp_ready;
   assign oBusy            = (state_q != IDLE);
   assign oDone            = (state_q == DONE);
   assign oState           = state_q;

endmodule

// File: tb/tb_rice_stream_writer.sv
`timescale 1ns/1ps
module tb_rice_stream_writer;
   import rice_pkg::*;

   // ---------------- clock / reset / DUT ----------------
   logic        iClock = 1'b0;
   logic        iReset;
   logic        iStart;
   logic [15:0] iBlockSize;
   logic [3:0]  iPartitionOrder;
   logic [3:0]  iPredictorOrder;
   logic        oBusy;
   logic        oDone;
   state_t      oState;

   rice_stream_writer_if bus ();

   rice_stream_writer dut (
      .iClock          (iClock),
      .iReset          (iReset),
      .iStart          (iStart),
      .iBlockSize      (iBlockSize),
      .iPartitionOrder (iPartitionOrder),
      .iPredictorOrder (iPredictorOrder),
      .bus             (bus),
      .oBusy           (oBusy),
      .oDone           (oDone),
      .oState          (oState)
   );

   always #5 iClock = ~iClock;

   initial begin
      #5ms;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // ---------------- counters ----------------
   int n_checks = 0;
   int n_fail   = 0;

   // ---------------- stimulus tables ----------------
   logic [3:0]  prm [16];
   logic [15:0] smp [16];

   // ---------------- monitor ----------------
   string got_s;
   int    bit_cnt, lead_zeros, done_cnt, p_cnt, s_cnt, stall_viol;
   int    psamp [16];
   bit    seen_one, prev_stall;
   logic  prev_bit;

   task automatic clear_mon();
      got_s = "";
      bit_cnt = 0; lead_zeros = 0; done_cnt = 0; p_cnt = 0; s_cnt = 0; stall_viol = 0;
      seen_one = 1'b0; prev_stall = 1'b0; prev_bit = 1'b0;
      for (int i = 0; i < 16; i++) psamp[i] = 0;
   endtask

   always @(negedge iClock) begin
      if (prev_stall) begin
         if (!(bus.oBitValid === 1'b1 && bus.oBit === prev_bit)) stall_viol++;
      end
      prev_stall = bus.oBitValid && !bus.iBitReady;
      prev_bit   = bus.oBit;
      if (bus.oBitValid && bus.iBitReady) begin
         if (bit_cnt < 200) begin
            if (bus.oBit) got_s = {got_s, "1"};
            else          got_s = {got_s, "0"};
         end
         if (!seen_one) begin
            if (bus.oBit) seen_one = 1'b1;
            else          lead_zeros++;
         end
         bit_cnt++;
      end
      if (bus.oParamReq && bus.iParamValid) p_cnt++;
      if (bus.oSampleReady && bus.iSampleValid) begin
         s_cnt++;
         if (p_cnt > 0 && p_cnt <= 16) psamp[p_cnt-1]++;
      end
      if (oDone) done_cnt++;
   end

   // ---------------- driver ----------------
   task automatic run_block(input logic [15:0] bs, input logic [3:0] po, input logic [3:0] pr,
                            input int np, input int ns, input bit stall, input bit glitch,
                            input int budget, output bit fin);
      int pi, si;
      bit tp, ts;
      clear_mon();
      pi = 0; si = 0; fin = 1'b0;
      @(posedge iClock); #1;
      iBlockSize = bs; iPartitionOrder = po; iPredictorOrder = pr; iStart = 1'b1;
      bus.iParamValid  = (np > 0); bus.iRiceParam = prm[0];
      bus.iSampleValid = (ns > 0); bus.iSample    = smp[0];
      bus.iBitReady    = 1'b1;
      @(posedge iClock); #1;
      iStart = 1'b0;
      for (int c = 0; c < budget && !fin; c++) begin
         @(negedge iClock);
         tp = bus.oParamReq && bus.iParamValid;
         ts = bus.oSampleReady && bus.iSampleValid;
         if (oDone) fin = 1'b1;
         @(posedge iClock); #1;
         if (tp) pi++;
         if (ts) si++;
         bus.iParamValid  = (pi < np);
         bus.iRiceParam   = prm[(pi < 16) ? pi : 15];
         bus.iSampleValid = (si < ns);
         bus.iSample      = smp[(si < 16) ? si : 15];
         bus.iBitReady    = stall ? ($urandom_range(0, 2) != 0) : 1'b1;
         iStart           = glitch && (c == 4);
      end
      iStart = 1'b0; bus.iParamValid = 1'b0; bus.iSampleValid = 1'b0; bus.iBitReady = 1'b1;
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      iReset = 1'b1; iStart = 1'b1;
      @(posedge iClock); @(posedge iClock); #1;
      n_checks++;
      if (oState !== IDLE) begin
         n_fail++; $display("FAIL reset_state: got %0d expected %0d", oState, IDLE);
      end
      n_checks++;
      if ({oBusy, oDone, bus.oBitValid, bus.oBit, bus.oSampleReady, bus.oParamReq} !== 6'b0) begin
         n_fail++;
         $display("FAIL reset_outputs: got %b expected 000000",
                  {oBusy, oDone, bus.oBitValid, bus.oBit, bus.oSampleReady, bus.oParamReq});
      end
      iReset = 1'b0; iStart = 1'b0;
      @(posedge iClock); #1;
   endtask

   task automatic test_basic(input string tag);
      bit fin;
      string exp_s;
      prm[0] = 4'd2; smp[0] = 16'd3;
      run_block(16'd1, 4'd0, 4'd0, 1, 1, 1'b0, 1'b0, 200, fin);
      exp_s = "000000"; exp_s = {exp_s, "0010"}; exp_s = {exp_s, "0110"};
      n_checks++;
      if (!fin) begin n_fail++; $display("FAIL %s_timeout: got no oDone expected oDone", tag); end
      n_checks++;
      if (got_s != exp_s) begin n_fail++; $display("FAIL %s_bits: got %s expected %s", tag, got_s, exp_s); end
      n_checks++;
      if (done_cnt != 1) begin n_fail++; $display("FAIL %s_done: got %0d expected 1", tag, done_cnt); end
   endtask

   task automatic test_fold();
      bit fin;
      string exp_s;
      prm[0] = 4'd2; smp[0] = 16'hFFFF;
      run_block(16'd1, 4'd0, 4'd0, 1, 1, 1'b0, 1'b0, 200, fin);
      exp_s = "000000"; exp_s = {exp_s, "0010"}; exp_s = {exp_s, "101"};
      n_checks++;
      if (got_s != exp_s) begin n_fail++; $display("FAIL fold_m1: got %s expected %s", got_s, exp_s); end
      prm[0] = 4'd0; smp[0] = 16'd0;
      run_block(16'd1, 4'd0, 4'd0, 1, 1, 1'b0, 1'b0, 200, fin);
      exp_s = "000000"; exp_s = {exp_s, "0000"}; exp_s = {exp_s, "1"};
      n_checks++;
      if (got_s != exp_s) begin n_fail++; $display("FAIL fold_zero: got %s expected %s", got_s, exp_s); end
   endtask

   task automatic test_unary_max();
      bit fin;
      prm[0] = 4'd0; smp[0] = 16'h8000;
      run_block(16'd1, 4'd0, 4'd0, 1, 1, 1'b0, 1'b0, 70000, fin);
      n_checks++;
      if (!fin) begin n_fail++; $display("FAIL unary_max_timeout: got no oDone expected oDone"); end
      // 10 header/parameter zeros precede the 65535 unary zeros
      n_checks++;
      if (lead_zeros != 65545) begin n_fail++; $display("FAIL unary_max_zeros: got %0d expected 65545", lead_zeros); end
      n_checks++;
      if (bit_cnt != 65546) begin n_fail++; $display("FAIL unary_max_len: got %0d expected 65546", bit_cnt); end
   endtask

   task automatic test_partitions();
      bit fin;
      string exp_s;
      int exp_ps [4];
      exp_ps[0] = 2; exp_ps[1] = 4; exp_ps[2] = 4; exp_ps[3] = 4;
      for (int i = 0; i < 16; i++) begin prm[i] = 4'd0; smp[i] = 16'd0; end
      run_block(16'd16, 4'd2, 4'd2, 4, 16, 1'b0, 1'b0, 400, fin);
      n_checks++;
      if (!fin) begin n_fail++; $display("FAIL part_timeout: got no oDone expected oDone"); end
      n_checks++;
      if (p_cnt != 4) begin n_fail++; $display("FAIL part_params: got %0d expected 4", p_cnt); end
      n_checks++;
      if (s_cnt != 14) begin n_fail++; $display("FAIL part_samples: got %0d expected 14", s_cnt); end
      for (int i = 0; i < 4; i++) begin
         n_checks++;
         if (psamp[i] != exp_ps[i]) begin
            n_fail++; $display("FAIL part_%0d_count: got %0d expected %0d", i, psamp[i], exp_ps[i]);
         end
      end
      exp_s = "000010"; exp_s = {exp_s, "000011"};
      exp_s = {exp_s, "00001111"}; exp_s = {exp_s, "00001111"}; exp_s = {exp_s, "00001111"};
      n_checks++;
      if (got_s != exp_s) begin n_fail++; $display("FAIL part_bits: got %s expected %s", got_s, exp_s); end
   endtask

   task automatic test_stall();
      bit fin;
      string exp_s, ref_s;
      prm[0] = 4'd3; smp[0] = 16'd5; smp[1] = 16'hFFFC;
      exp_s = "000000"; exp_s = {exp_s, "0011"}; exp_s = {exp_s, "01010"}; exp_s = {exp_s, "1111"};
      run_block(16'd2, 4'd0, 4'd0, 1, 2, 1'b0, 1'b0, 300, fin);
      ref_s = got_s;
      n_checks++;
      if (ref_s != exp_s) begin n_fail++; $display("FAIL nostall_bits: got %s expected %s", ref_s, exp_s); end
      run_block(16'd2, 4'd0, 4'd0, 1, 2, 1'b1, 1'b1, 600, fin);
      n_checks++;
      if (!fin) begin n_fail++; $display("FAIL stall_timeout: got no oDone expected oDone"); end
      n_checks++;
      if (got_s != exp_s) begin n_fail++; $display("FAIL stall_bits: got %s expected %s", got_s, exp_s); end
      n_checks++;
      if (stall_viol != 0) begin n_fail++; $display("FAIL stall_hold: got %0d unstable cycles expected 0", stall_viol); end
      n_checks++;
      if (done_cnt != 1) begin n_fail++; $display("FAIL stall_done: got %0d expected 1", done_cnt); end
   endtask

   task automatic test_reset_mid_unary();
      bit fin;
      prm[0] = 4'd0; smp[0] = 16'h8000;
      run_block(16'd1, 4'd0, 4'd0, 1, 1, 1'b0, 1'b0, 60, fin);
      n_checks++;
      if (fin) begin n_fail++; $display("FAIL midrst_early_done: got oDone expected none"); end
      n_checks++;
      if (oState !== UNARY) begin n_fail++; $display("FAIL midrst_pre_state: got %0d expected %0d", oState, UNARY); end
      iReset = 1'b1;
      @(posedge iClock); #1;
      n_checks++;
      if (oState !== IDLE) begin n_fail++; $display("FAIL midrst_state: got %0d expected %0d", oState, IDLE); end
      n_checks++;
      if ({oBusy, oDone, bus.oBitValid, bus.oBit, bus.oSampleReady, bus.oParamReq} !== 6'b0) begin
         n_fail++;
         $display("FAIL midrst_outputs: got %b expected 000000",
                  {oBusy, oDone, bus.oBitValid, bus.oBit, bus.oSampleReady, bus.oParamReq});
      end
      iReset = 1'b0;
      test_basic("after_reset");
   endtask

   task automatic test_escape();
      bit fin;
      string exp_s;
      prm[0] = 4'd15; smp[0] = 16'd5;
      run_block(16'd1, 4'd0, 4'd0, 1, 1, 1'b0, 1'b0, 200, fin);
`ifdef RICE_ESCAPE_EN
      exp_s = "000000"; exp_s = {exp_s, "1111"}; exp_s = {exp_s, "10000"};
      exp_s = {exp_s, "0000000000000101"};
`else
      exp_s = "000000"; exp_s = {exp_s, "1110"}; exp_s = {exp_s, "1"};
      exp_s = {exp_s, "00000000001010"};
`endif
      n_checks++;
      if (got_s != exp_s) begin n_fail++; $display("FAIL escape_bits: got %s expected %s", got_s, exp_s); end
      n_checks++;
      if (done_cnt != 1) begin n_fail++; $display("FAIL escape_done: got %0d expected 1", done_cnt); end
   endtask

   // ---------------- sequence / report ----------------
   initial begin
      iReset = 1'b1; iStart = 1'b0;
      iBlockSize = '0; iPartitionOrder = '0; iPredictorOrder = '0;
      bus.iRiceParam = '0; bus.iParamValid = 1'b0;
      bus.iSample = '0; bus.iSampleValid = 1'b0; bus.iBitReady = 1'b1;
      for (int i = 0; i < 16; i++) begin prm[i] = '0; smp[i] = '0; end
      clear_mon();
      test_reset();
      test_basic("basic");
      test_fold();
      test_partitions();
      test_stall();
      test_reset_mid_unary();
      test_escape();
      test_unary_max();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/rice_stream_writer.md
RICE_STREAM_WRITER -- requirements
Module: rice_stream_writer

Interface
REQ-001 SHALL have port iClock, input, 1 bit: rising-edge clock for all state.
REQ-002 SHALL have port iReset, input, 1 bit: reset, synchronous, active-high.
REQ-003 SHALL have port iStart, input, 1: one-cycle pulse that begins one residual block; ignored unless IDLE.
REQ-004 SHALL have port iBlockSize, input, 16: samples per block; captured on accepted iStart.
REQ-005 SHALL have port iPartitionOrder, input, 4: captured on accepted iStart.
REQ-006 SHALL have port iPredictorOrder, input, 4: warm-up sample count; captured on accepted iStart.
REQ-007 SHALL have ports iRiceParam (input, 4) and iParamValid (input, 1): per-partition parameter, accepted when oParamReq&&iParamValid.
REQ-008 SHALL have port oParamReq, output, 1: high while waiting for a partition parameter.
REQ-009 SHALL have ports iSample (input, signed 16), iSampleValid (input, 1) and oSampleReady (output, 1): residual handshake; transfer on valid&&ready.
REQ-010 SHALL have ports oBit (output, 1), oBitValid (output, 1) and iBitReady (input, 1): serial MSB-first bitstream; transfer on valid&&ready.
REQ-011 SHALL have ports oBusy (output, 1: not IDLE) and oDone (output, 1: one-cycle pulse after the last bit of the block transfers).

Function
REQ-012 SHALL run states IDLE, HDR, PWAIT, PARAM, SWAIT, UNARY, STOP, LSB, DONE (plus ESCW and RAW with the macro).
REQ-013 SHALL move IDLE->HDR on iStart; HDR emits 6 bits: 2'b00 (coding method), then partition order.
REQ-014 SHALL use 1<<order partitions: partition 0 holds (iBlockSize>>order)-iPredictorOrder samples, the others iBlockSize>>order; legality is the caller's duty and is unchecked.
REQ-015 SHALL per partition: PWAIT asserts oParamReq; accepting a parameter moves to PARAM, which emits the 4-bit parameter, then goes to SWAIT.
REQ-016 SHALL assert oSampleReady only in SWAIT; on a transfer, fold u = (x<<1) ^ (x>>>15) (16-bit unsigned) and set q = u>>k, r = u[k-1:0].
REQ-017 SHALL emit q zero bits (UNARY, skipped if q=0), one '1' bit (STOP), then k bits of r MSB-first (LSB, skipped if k=0).
REQ-018 SHALL return after the last bit of a sample to SWAIT if the partition has samples left, else to PWAIT for the next partition, else to DONE; DONE pulses oDone and returns to IDLE.
REQ-019 SHALL drive the first bit of a sample on oBitValid in the cycle after the sample transfer; with iBitReady held high, output is one bit per cycle with no bubbles inside a state.
REQ-020 SHALL hold oBit stable while oBitValid=1 and iBitReady=0, with no counter advance.
REQ-021 SHALL ignore iStart while oBusy=1, and ignore iSampleValid/iParamValid outside SWAIT/PWAIT.
REQ-022 SHALL use a 16-bit unary counter; q=65535 (x=-32768, k=0) emits exactly 65535 zeros.

Reset
REQ-023 SHALL on iReset go to IDLE and zero oBit, oBitValid, oSampleReady, oParamReq, oBusy, oDone and all counters, in any state, mid-sample included.
REQ-024 SHALL have iReset take priority over iStart in the same cycle.

Configuration
REQ-025 SHALL, when RICE_ESCAPE_EN is defined, treat parameter 15 as escape: emit 4'b1111, then 5'd16 (ESCW), then every partition sample as 16 raw two's-complement bits MSB-first (RAW).
REQ-026 SHALL, when RICE_ESCAPE_EN is undefined, saturate parameter 15 to 14, both in the emitted parameter field and in the encoding.

Structure
REQ-027 SHALL place the state enum, RICE_PARAM_W=4, SAMPLE_W=16, HDR_W=6 and RICE_ESCAPE=4'hF in shared package rice_pkg.
REQ-028 SHALL instantiate one sub-module, rice_fold (combinational signed-to-unsigned zigzag fold), shared with future encoder blocks.

Verification
REQ-029 SHALL check: block 1, order 0, pred 0, param 2, sample 3 -> bits 000000 0010 0 1 10, then oDone.
REQ-030 SHALL check: sample -1, k=2 -> 1 01; sample 0, k=0 -> single 1; sample -32768, k=0 -> 65535 zeros then 1.
REQ-031 SHALL check: block 16, order 2, pred 2 -> oParamReq 4 times, 2/4/4/4 samples accepted, 14 total.
REQ-032 SHALL check: random iBitReady low stretches -> the bit sequence is identical to the no-stall run and oBit is stable while stalled.
REQ-033 SHALL check: iReset asserted mid-UNARY -> next cycle IDLE, all outputs 0, and a fresh block then encodes correctly.
REQ-034 SHALL check: param 15, sample 5 -> with macro 1111 10000 0000000000000101; without macro 1110 then 1 + 14-bit r=10.
